// File: rtl/axis_pkg.sv
// Shared AXI-Stream width-converter types: FSM state encoding and index sizing helper.
package axis_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_downsizer_if.sv
// AXI-Stream bundle with master/slave views; tkeep exists only when
// AXIS_DOWNSIZER_TKEEP_EN is defined.
interface axis_downsizer_if #(
  parameter int DW = 8
);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tlast;
  logic          tready;
`ifdef AXIS_DOWNSIZER_TKEEP_EN
  logic [DW/8-1:0] tkeep;

  modport master (output tdata, tvalid, tlast, tkeep, input tready);
  modport slave  (input tdata, tvalid, tlast, tkeep, output tready);
`else
  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
`endif
endinterface

// File: rtl/axis_lane_sel.sv
// Combinational lane mux: picks narrow lane idx out of a wide word, in send order.
module axis_lane_sel #(
  parameter int S_WIDTH   = 32,
  parameter int M_WIDTH   = 8,
  parameter int MSB_FIRST = 1,
  parameter int IDX_W     = 2
) (
  input  logic [S_WIDTH-1:0] wide,
  input  logic [IDX_W-1:0]   idx,
  output logic [M_WIDTH-1:0] lane
);
  localparam int RATIO = S_WIDTH / M_WIDTH;

  logic [M_WIDTH-1:0] lanes [RATIO];

  for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
    if (MSB_FIRST != 0) begin : g_msb
      assign lanes[gi] = wide[S_WIDTH-1-gi*M_WIDTH -: M_WIDTH];
    end else begin : g_lsb
      assign lanes[gi] = wide[gi*M_WIDTH +: M_WIDTH];
    end
  end

  // Compare-based select stays well defined when RATIO is not a power of two.
  always_comb begin
    lane = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (idx == IDX_W'(i)) lane = lanes[i];
    end
  end
endmodule

// File: rtl/axis_downsizer.sv
// AXI-Stream width downconverter, S_WIDTH -> M_WIDTH with backpressure and tx_done pulse.
// Optional byte enables and last-beat truncation under AXIS_DOWNSIZER_TKEEP_EN.
module axis_downsizer
  import axis_pkg::*;
#(
  parameter int S_WIDTH   = 32,
  parameter int M_WIDTH   = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                      aclk,
  input  logic                      areset,
  axis_downsizer_if.slave           s_axis,
  axis_downsizer_if.master          m_axis,
  output logic                      tx_done
);
  localparam int RATIO = S_WIDTH / M_WIDTH;
  localparam int IDX_W = clog2_min1(RATIO);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  if (S_WIDTH % M_WIDTH != 0) begin : g_chk_div
    $error("axis_downsizer: S_WIDTH must be a multiple of M_WIDTH");
  end
  if (RATIO < 2) begin : g_chk_ratio
    $error("axis_downsizer: S_WIDTH/M_WIDTH must be at least 2");
  end
  if (M_WIDTH % 8 != 0) begin : g_chk_byte
    $error("axis_downsizer: M_WIDTH must be a multiple of 8");
  end

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [S_WIDTH-1:0] data_buf_reg;
  logic               last_reg;
  logic               tx_done_reg;
  logic [IDX_W-1:0]   final_idx;
  logic               load;
  logic               s_ready;
  logic               m_valid;
  logic               m_last;

  axis_lane_sel #(
    .S_WIDTH(S_WIDTH), .M_WIDTH(M_WIDTH), .MSB_FIRST(MSB_FIRST), .IDX_W(IDX_W)
  ) u_data_sel (
    .wide(data_buf_reg), .idx(idx_reg), .lane(m_axis.tdata)
  );

`ifdef AXIS_DOWNSIZER_TKEEP_EN
  localparam int SK = S_WIDTH / 8;
  localparam int MK = M_WIDTH / 8;

  logic [SK-1:0]    keep_buf_reg;
  logic [RATIO-1:0] lane_valid;

  // lane_valid is indexed in send order so final_idx lines up with idx_reg.
  for (genvar gi = 0; gi < RATIO; gi++) begin : g_keep
    if (MSB_FIRST != 0) begin : g_msb
      assign lane_valid[gi] = |keep_buf_reg[SK-1-gi*MK -: MK];
    end else begin : g_lsb
      assign lane_valid[gi] = |keep_buf_reg[gi*MK +: MK];
    end
  end

  // Last wide beat stops after its last populated lane; all-empty sends lane 0 only.
  always_comb begin
    final_idx = LAST_IDX;
    if (last_reg) begin
      final_idx = '0;
      for (int i = 0; i < RATIO; i++) begin
        if (lane_valid[i]) final_idx = IDX_W'(i);
      end
    end
  end

  axis_lane_sel #(
    .S_WIDTH(SK), .M_WIDTH(MK), .MSB_FIRST(MSB_FIRST), .IDX_W(IDX_W)
  ) u_keep_sel (
    .wide(keep_buf_reg), .idx(idx_reg), .lane(m_axis.tkeep)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      keep_buf_reg <= '0;
    end else if (load) begin
      keep_buf_reg <= s_axis.tkeep;
    end
  end
`else
  assign final_idx = LAST_IDX;
`endif

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    load       = 1'b0;
    s_ready    = 1'b0;
    m_valid    = 1'b0;
    case (state_reg)
      IDLE: begin
        s_ready = 1'b1;
        if (s_axis.tvalid) begin
          load       = 1'b1;
          idx_next   = '0;
          state_next = SEND;
        end
      end
      SEND: begin
        m_valid = 1'b1;
        if (idx_reg == final_idx) begin
          // Accepting the next wide beat on the final lane avoids a bubble.
          s_ready = m_axis.tready;
          if (m_axis.tready) begin
            if (s_axis.tvalid) begin
              load     = 1'b1;
              idx_next = '0;
            end else begin
              state_next = IDLE;
            end
          end
        end else if (m_axis.tready) begin
          idx_next = idx_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign m_last = m_valid && last_reg && (idx_reg == final_idx);

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      data_buf_reg <= '0;
      last_reg     <= 1'b0;
      tx_done_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      tx_done_reg <= m_last && m_axis.tready;
      if (load) begin
        data_buf_reg <= s_axis.tdata;
        last_reg     <= s_axis.tlast;
      end
    end
  end

  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = m_valid;
  assign m_axis.tlast  = m_last;
  assign tx_done       = tx_done_reg;
endmodule

// File: tb/tb_axis_downsizer.sv
// Randomised scoreboard bench for axis_downsizer; runs an MSB-first and an LSB-first
// instance side by side, each with its own slave stream.
`timescale 1ns/1ps
module tb_axis_downsizer;
  localparam int S  = 32;
  localparam int M  = 8;
  localparam int R  = S / M;
  localparam int SK = S / 8;
  localparam int MK = M / 8;

  typedef struct {
    logic [M-1:0]  data;
    logic          last;
    logic [MK-1:0] keep;
  } beat_t;

  typedef struct {
    logic [S-1:0]  data;
    logic          last;
    logic [SK-1:0] keep;
  } word_t;

  logic clk = 1'b0;
  logic areset = 1'b1;
  logic m_tready = 1'b0;
  logic          s_tvalid [2];
  logic [S-1:0]  s_tdata  [2];
  logic          s_tlast  [2];
`ifdef AXIS_DOWNSIZER_TKEEP_EN
  logic [SK-1:0] s_tkeep  [2];
  logic [MK-1:0] m_tkeep_o [2];
`endif
  logic [1:0]    tx_done_o, m_tvalid_o, m_tlast_o, s_tready_o;
  logic [M-1:0]  m_tdata_o [2];

  always #5 clk = ~clk;

  axis_downsizer_if #(.DW(S)) if_sa ();
  axis_downsizer_if #(.DW(M)) if_ma ();
  axis_downsizer_if #(.DW(S)) if_sb ();
  axis_downsizer_if #(.DW(M)) if_mb ();

  assign if_sa.tdata  = s_tdata[0];
  assign if_sa.tvalid = s_tvalid[0];
  assign if_sa.tlast  = s_tlast[0];
  assign if_sb.tdata  = s_tdata[1];
  assign if_sb.tvalid = s_tvalid[1];
  assign if_sb.tlast  = s_tlast[1];
  assign if_ma.tready = m_tready;
  assign if_mb.tready = m_tready;
  assign s_tready_o   = {if_sb.tready, if_sa.tready};
  assign m_tvalid_o   = {if_mb.tvalid, if_ma.tvalid};
  assign m_tlast_o    = {if_mb.tlast, if_ma.tlast};
  assign m_tdata_o[0] = if_ma.tdata;
  assign m_tdata_o[1] = if_mb.tdata;
`ifdef AXIS_DOWNSIZER_TKEEP_EN
  assign if_sa.tkeep  = s_tkeep[0];
  assign if_sb.tkeep  = s_tkeep[1];
  assign m_tkeep_o[0] = if_ma.tkeep;
  assign m_tkeep_o[1] = if_mb.tkeep;
`endif

  axis_downsizer #(.S_WIDTH(S), .M_WIDTH(M), .MSB_FIRST(1)) dut_msb (
    .aclk(clk), .areset(areset), .s_axis(if_sa), .m_axis(if_ma), .tx_done(tx_done_o[0])
  );
  axis_downsizer #(.S_WIDTH(S), .M_WIDTH(M), .MSB_FIRST(0)) dut_lsb (
    .aclk(clk), .areset(areset), .s_axis(if_sb), .m_axis(if_mb), .tx_done(tx_done_o[1])
  );

  word_t pend [2][$];
  beat_t q    [2][$];
  logic  tx_exp [2];
  logic  hold   [2];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference: lane i in send order is the i-th M-bit slice counted from the chosen end.
  task automatic expand(input int d, input word_t w);
    logic [M-1:0]  ld [R];
    logic [MK-1:0] lk [R];
    int n;
    int sh;
    n = R;
    for (int i = 0; i < R; i++) begin
      sh    = (d == 0) ? (R - 1 - i) : i;
      ld[i] = M'(w.data >> (sh * M));
      lk[i] = MK'(w.keep >> (sh * MK));
    end
`ifdef AXIS_DOWNSIZER_TKEEP_EN
    if (w.last) begin
      n = 1;
      for (int i = 0; i < R; i++) if (lk[i] != '0) n = i + 1;
    end
`endif
    for (int i = 0; i < n; i++) q[d].push_back('{ld[i], w.last && (i == n - 1), lk[i]});
  endtask

  task automatic push(input logic [S-1:0] w, input logic l, input logic [SK-1:0] k);
    for (int d = 0; d < 2; d++) pend[d].push_back('{w, l, k});
  endtask

  function automatic bit busy();
    return pend[0].size() != 0 || pend[1].size() != 0 || q[0].size() != 0 || q[1].size() != 0;
  endfunction

  // One clock: drive inputs, check outputs at the falling edge, advance the model.
  task automatic step(input bit rnd_valid, input bit rdy);
    logic  exp_sr;
    bit    s_hs, m_hs;
    string tg;
    m_tready = rdy;
    for (int d = 0; d < 2; d++) begin
      if (areset) s_tvalid[d] = 1'b0;
      else if (!hold[d])
        s_tvalid[d] = (pend[d].size() != 0) && (!rnd_valid || $urandom_range(0, 3) != 0);
      if (s_tvalid[d]) begin
        s_tdata[d] = pend[d][0].data;
        s_tlast[d] = pend[d][0].last;
`ifdef AXIS_DOWNSIZER_TKEEP_EN
        s_tkeep[d] = pend[d][0].keep;
`endif
      end
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      tg = (d == 0) ? "msb" : "lsb";
      exp_sr = (q[d].size() == 0) ? 1'b1 : ((q[d].size() == 1) ? rdy : 1'b0);
      chk({tg, ".tvalid"}, 64'(m_tvalid_o[d]), 64'(q[d].size() != 0));
      chk({tg, ".s_tready"}, 64'(s_tready_o[d]), 64'(exp_sr));
      chk({tg, ".tx_done"}, 64'(tx_done_o[d]), 64'(tx_exp[d]));
      if (q[d].size() != 0) begin
        chk({tg, ".tdata"}, 64'(m_tdata_o[d]), 64'(q[d][0].data));
        chk({tg, ".tlast"}, 64'(m_tlast_o[d]), 64'(q[d][0].last));
`ifdef AXIS_DOWNSIZER_TKEEP_EN
        chk({tg, ".tkeep"}, 64'(m_tkeep_o[d]), 64'(q[d][0].keep));
`endif
      end
      if (areset) begin
        q[d].delete();
        tx_exp[d] = 1'b0;
        hold[d]   = 1'b0;
      end else begin
        s_hs = s_tvalid[d] && exp_sr;
        m_hs = (q[d].size() != 0) && rdy;
        tx_exp[d] = m_hs && q[d][0].last;
        if (m_hs) void'(q[d].pop_front());
        if (s_hs) expand(d, pend[d].pop_front());
        hold[d] = s_tvalid[d] && !s_hs;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset();
    for (int d = 0; d < 2; d++) begin
      chk("rst.tvalid", 64'(m_tvalid_o[d]), 64'(0));
      chk("rst.tlast", 64'(m_tlast_o[d]), 64'(0));
      chk("rst.tdata", 64'(m_tdata_o[d]), 64'(0));
      chk("rst.tx_done", 64'(tx_done_o[d]), 64'(0));
      chk("rst.s_tready", 64'(s_tready_o[d]), 64'(1));
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      s_tvalid[d] = 1'b0;
      s_tdata[d]  = '0;
      s_tlast[d]  = 1'b0;
      tx_exp[d]   = 1'b0;
      hold[d]     = 1'b0;
`ifdef AXIS_DOWNSIZER_TKEEP_EN
      s_tkeep[d]  = '0;
`endif
    end
    repeat (3) step(0, 0);
    check_reset();
    areset = 1'b0;

    // Single-beat packet, both lane orders.
    push(32'hA1B2C3D4, 1'b1, '1);
    repeat (8) step(0, 1);

    // Back-to-back wide beats with no gap.
    push(32'h01020304, 1'b0, '1);
    push(32'h05060708, 1'b1, '1);
    repeat (12) step(0, 1);

    // Backpressure pattern 1,0,0,1,0,0,...
    push(32'h0A0B0C0D, 1'b0, '1);
    push(32'h1A1B1C1D, 1'b1, '1);
    for (int k = 0; k < 30; k++) step(0, (k % 3) == 0);

    // Reset in mid-packet when lane index 2 is presented.
    push(32'hCAFEF00D, 1'b1, '1);
    for (int k = 0; k < 20 && q[0].size() != 2; k++) step(0, 1);
    if (q[0].size() != 2) chk("reach_idx2", 64'(q[0].size()), 64'(2));
    areset = 1'b1;
    step(0, 1);
    areset = 1'b0;
    check_reset();
    push(32'h11223344, 1'b1, '1);
    repeat (8) step(0, 1);

`ifdef AXIS_DOWNSIZER_TKEEP_EN
    // Truncated last beat: lowest lane empty.
    push(32'hAABBCC00, 1'b1, 4'b1110);
    repeat (8) step(0, 1);
    push(32'h55667788, 1'b1, 4'b0000);
    repeat (6) step(0, 1);
`endif

    for (int k = 0; k < 800; k++) begin
      if (pend[0].size() < 2 && pend[1].size() < 2)
        push($urandom, $urandom_range(0, 2) == 0,
             ($urandom_range(0, 3) == 0) ? SK'(0) : SK'($urandom));
      step(1, $urandom_range(0, 1) == 1);
    end

    for (int k = 0; k < 300 && busy(); k++) step(0, 1);
    if (busy()) chk("drain_timeout", 64'(1), 64'(0));
    repeat (2) step(0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
